// File: rtl/rr_encoded_arbiter_pkg.sv
// Shared types and defaults for the round-robin encoded arbiter.
package arb_pkg;

  localparam int unsigned DEF_N        = 4;
  localparam int unsigned DEF_MAX_HOLD = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Advance a priority pointer by one, wrapping at n-1 -> 0.
  function automatic int unsigned ptr_inc(input int unsigned p, input int unsigned n);
    return (p + 1 >= n) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/rr_encoded_arbiter_encoder.sv
// N-input one-hot to binary encoder; zero or multi-hot input encodes as 0.
module onehot_encoder #(
  parameter int unsigned N = 4,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] onehot,
  output logic [W-1:0] idx
);

  logic [W-1:0] acc;
  int unsigned  ones;

  always_comb begin
    acc  = '0;
    ones = 0;
    for (int unsigned i = 0; i < N; i++) begin
      if (onehot[i]) begin
        acc  = acc | W'(i);
        ones = ones + 1;
      end
    end
    idx = (ones == 1) ? acc : '0;
  end

endmodule

// File: rtl/rr_encoded_arbiter.sv
// Round-robin arbiter with registered one-hot grant and encoded index.
// Optional hold watchdog enabled by defining ARB_TIMEOUT_EN.
module rr_encoded_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned N        = DEF_N,
  parameter int unsigned IDX_W    = $clog2(N),
  parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout
);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [N-1:0]     next_grant;
  logic [IDX_W-1:0] next_idx;
  logic             found;
  int unsigned      pos;
  logic             natural_rel;
  logic             force_rel;
  logic             release_now;

  // Scan ptr, ptr+1, ... wrapping, and take the first requester found.
  always_comb begin
    next_grant = '0;
    found      = 1'b0;
    pos        = 0;
    for (int unsigned i = 0; i < N; i++) begin
      pos = (int'(ptr) + i) % N;
      if (!found && req[pos[IDX_W-1:0]]) begin
        next_grant[pos[IDX_W-1:0]] = 1'b1;
        found                      = 1'b1;
      end
    end
  end

  onehot_encoder #(
    .N (N),
    .W (IDX_W)
  ) u_enc (
    .onehot (next_grant),
    .idx    (next_idx)
  );

  assign natural_rel = done | ~req[grant_idx];
  assign release_now = natural_rel | force_rel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant       <= next_grant;
            grant_idx   <= next_idx;
            grant_valid <= 1'b1;
            state       <= GRANT;
          end
        end
        GRANT: begin
          // grant_idx deliberately keeps its last value across release.
          if (release_now) begin
            grant       <= '0;
            grant_valid <= 1'b0;
            ptr         <= IDX_W'(ptr_inc(int'(grant_idx), N));
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);

  logic [CNT_W-1:0] hold_cnt;
  logic             timeout_q;

  // The edge that completes MAX_HOLD grant cycles is the forced release edge.
  assign force_rel = (state == GRANT) && !natural_rel &&
                     (hold_cnt == CNT_W'(MAX_HOLD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= force_rel;
      if (state == GRANT) begin
        hold_cnt <= hold_cnt + 1'b1;
      end else begin
        hold_cnt <= '0;
      end
    end
  end

  assign timeout = timeout_q;
`else
  assign force_rel = 1'b0;
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_encoded_arbiter.sv
// Directed self-checking bench for rr_encoded_arbiter (N=4).
module tb_rr_encoded_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  int vectors;
  int miscompares;

  rr_encoded_arbiter #(
    .N        (4),
    .IDX_W    (2),
    .MAX_HOLD (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [1:0] idx,
                         input logic v);
    chk({tag, ".grant"}, {28'd0, grant}, {28'd0, g});
    chk({tag, ".idx"}, {30'd0, grant_idx}, {30'd0, idx});
    chk({tag, ".valid"}, {31'd0, grant_valid}, {31'd0, v});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rr_exp [5] = '{0, 1, 2, 3, 0};
    vectors     = 0;
    miscompares = 0;
    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;

    #3;
    chk_out("reset", 4'b0000, 2'd0, 1'b0);
    chk("reset.timeout", {31'd0, timeout}, 32'd0);
    step();
    step();
    rst = 1'b0;
    step();
    chk_out("idle_noreq", 4'b0000, 2'd0, 1'b0);

    // Single request, held three cycles, released by done.
    req = 4'b0100;
    step();
    chk_out("single.grant", 4'b0100, 2'd2, 1'b1);
    step();
    step();
    chk_out("single.hold", 4'b0100, 2'd2, 1'b1);
    done = 1'b1;
    step();
    chk_out("single.release", 4'b0000, 2'd2, 1'b0);
    done = 1'b0;
    req  = 4'b0000;
    step();
    chk_out("single.idle", 4'b0000, 2'd2, 1'b0);

    // ptr=3 now: req=0011 wraps to requester 0, then 1.
    req = 4'b0011;
    step();
    chk_out("wrap.first", 4'b0001, 2'd0, 1'b1);
    done = 1'b1;
    step();
    chk_out("wrap.release", 4'b0000, 2'd0, 1'b0);
    done = 1'b0;
    step();
    chk_out("wrap.second", 4'b0010, 2'd1, 1'b1);

    // Granted requester drops its request: release, ptr=2.
    req = 4'b0001;
    step();
    chk_out("drop.release", 4'b0000, 2'd1, 1'b0);
    req = 4'b1111;
    step();
    chk_out("drop.next", 4'b0100, 2'd2, 1'b1);
    // done and req drop together: one release, ptr=3.
    req  = 4'b1011;
    done = 1'b1;
    step();
    chk_out("both.release", 4'b0000, 2'd2, 1'b0);
    req  = 4'b1111;
    done = 1'b0;
    step();
    chk_out("both.next", 4'b1000, 2'd3, 1'b1);
    done = 1'b1;
    step();
    chk_out("both.release2", 4'b0000, 2'd3, 1'b0);

    // Round robin with done held high (ignored while idle).
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rr.idx", {30'd0, grant_idx}, rr_exp[k]);
      chk("rr.grant", {28'd0, grant}, 32'd1 << rr_exp[k]);
      chk("rr.valid", {31'd0, grant_valid}, 32'd1);
      step();
      chk("rr.gap", {31'd0, grant_valid}, 32'd0);
    end
    done = 1'b0;

    // ptr=1: grant requester 1, then others asserting must not preempt.
    req = 4'b0010;
    step();
    chk_out("nopre.grant", 4'b0010, 2'd1, 1'b1);
    req = 4'b1111;
    step();
    chk_out("nopre.hold", 4'b0010, 2'd1, 1'b1);

    // Asynchronous reset mid-grant, checked before the next clock edge.
    #2;
    rst = 1'b1;
    #1;
    chk_out("async_rst", 4'b0000, 2'd0, 1'b0);
    #2;
    rst = 1'b0;
    step();
    chk_out("post_rst", 4'b0001, 2'd0, 1'b1);

`ifdef ARB_TIMEOUT_EN
    for (int c = 0; c < 15; c++) begin
      step();
      chk("wd.held", {31'd0, grant_valid}, 32'd1);
      chk("wd.quiet", {31'd0, timeout}, 32'd0);
    end
    step();
    chk_out("wd.forced", 4'b0000, 2'd0, 1'b0);
    chk("wd.pulse", {31'd0, timeout}, 32'd1);
    step();
    chk("wd.pulse_end", {31'd0, timeout}, 32'd0);
    chk_out("wd.next", 4'b0010, 2'd1, 1'b1);
`else
    repeat (39) step();
    chk_out("nowd.held40", 4'b0001, 2'd0, 1'b1);
    chk("nowd.timeout", {31'd0, timeout}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_encoded_arbiter.md
Name: rr_encoded_arbiter

Overview:
Round-robin arbiter sharing one downstream resource among N requesters.
It issues a one-hot grant plus its binary-encoded index. The index is produced by a one-hot-to-binary encoder, the N-input generalisation of the team's 2-to-1 encoder.
Sits between requester blocks and a shared datapath (e.g. bus or mux select); the resource drives done to release.

Parameters:
N, 4, number of requesters (2..16)
IDX_W, $clog2(N), width of encoded grant index
MAX_HOLD, 16, watchdog hold limit in cycles (used only with ARB_TIMEOUT_EN)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, asynchronous, active-high
req  input  N  request vector, bit i = requester i
done  input  1  resource releases current grant
grant  output  N  one-hot grant, registered
grant_idx  output  IDX_W  binary index of granted requester, registered
grant_valid  output  1  high while any grant held
timeout  output  1  one-cycle pulse on forced release (0 when ARB_TIMEOUT_EN undefined)

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-high.
- Reset values:
  - grant=0, grant_idx=0, grant_valid=0, timeout=0.
  - Priority pointer ptr=0; state=IDLE.
  - Assertion clears all outputs immediately, including mid-grant. First arbitration happens on the first clk edge after deassertion.
- States: IDLE, GRANT.
- IDLE:
  - If req!=0 at clk edge, select first set bit scanning ptr, ptr+1, ... wrapping at N-1 -> 0.
  - Register grant/grant_idx/grant_valid=1 and go to GRANT.
  - Latency: req sampled at edge k, grant visible after edge k.
  - req==0: stay IDLE, outputs 0.
- GRANT:
  - Outputs held stable.
  - Release when done==1 OR req[grant_idx]==0 at an edge. Both conditions true at once counts as a single release.
  - On release: grant, grant_valid -> 0; grant_idx holds its last value; ptr <= (grant_idx+1) mod N (wrap at N-1 -> 0); go to IDLE.
- Minimum one IDLE cycle between grants. Max grant rate is 1 per 2 cycles.
- done in IDLE: ignored.
- Requests from non-granted requesters during GRANT do not preempt.
- Fairness: with all req set, grants cycle 0,1,...,N-1,0. A requester waits at most N-1 grants.
- Invariants: grant is always one-hot or zero; grant_idx equals the encoding of grant whenever grant_valid=1.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - hold counter, width $clog2(MAX_HOLD+1), cleared on entry to GRANT and incremented each GRANT cycle.
  - If it reaches MAX_HOLD with no release, force release (same ptr update).
  - timeout pulses 1 for one cycle, coincident with grant_valid falling.
  - Counter reset to 0 by rst.
- Undefined: no counter; timeout tied 0; grants held indefinitely until done or req drop.

Decomposition:
- Package arb_pkg:
  - state typedef (IDLE, GRANT);
  - default N/MAX_HOLD localparams;
  - mod-N pointer increment function.
- Sub-module onehot_encoder (parameter N): combinational one-hot -> binary. Outputs 0 for zero or multi-hot input, matching the 2-to-1 encoder's default. Used to derive grant_idx from the next-grant vector.

Test Plan:
- Reset/idle: assert rst mid-grant (grant=0010) -> grant=0000, grant_valid=0 without waiting for clk. After release, req=0000 keeps outputs 0.
- Single request: req=0100 at edge k -> after k: grant=0100, grant_idx=2, grant_valid=1. done=1 at edge k+3 -> grant=0000 after k+3, ptr=3.
- Round robin: req=1111 held, done pulsed each GRANT cycle -> grant_idx sequence 0,1,2,3,0 with one idle cycle between each.
- Wrap/priority: ptr=3, req=0011 -> grant_idx=0. Next arbitration with req=0011 -> grant_idx=1.
- Req drop: grant_idx=1, req[1] falls with done=0 -> release next edge, ptr=2. done=1 same edge gives a single release, not a double.
- ARB_TIMEOUT_EN, MAX_HOLD=16: grant held, done=0, req steady -> forced release after 16 GRANT cycles, timeout=1 for exactly 1 cycle. Without macro, grant still held at cycle 40.
